// File: rtl/hazard_pkg.sv
// Shared constants and types for the hazard controller of the 5-stage core.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/hazard_unit_mc_if.sv
// Datapath <-> hazard controller signal bundle; the datapath is the master.
interface hazard_unit_mc_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] Rs1D, Rs2D;
    logic [REG_AW-1:0] Rs1E, Rs2E, RdE;
    logic [REG_AW-1:0] RdM, RdW;
    logic              RegWriteM, RegWriteW;
    logic [1:0]        ResultSrcE;
    logic              MdStartE;
    logic              PCSrcE;

    logic [1:0]        ForwardAE, ForwardBE;
    logic              lwStall;
    logic              MdBusy;
    logic              StallF, StallD, StallE;
    logic              FlushD, FlushE, FlushM;
    logic [CNT_W-1:0]  StallCycles, FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, ResultSrcE, MdStartE, PCSrcE,
        input  ForwardAE, ForwardBE, lwStall, MdBusy,
               StallF, StallD, StallE, FlushD, FlushE, FlushM,
               StallCycles, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
               RegWriteM, RegWriteW, ResultSrcE, MdStartE, PCSrcE,
        output ForwardAE, ForwardBE, lwStall, MdBusy,
               StallF, StallD, StallE, FlushD, FlushE, FlushM,
               StallCycles, FlushCount
    );
endinterface

// File: rtl/hazard_md_timer.sv
// Multi-cycle execute sequencer: holds an E-stage mul/div for MD_LAT cycles
// (MD_LAT-1 stalled cycles plus one release cycle).
module hazard_md_timer
    import hazard_pkg::*;
#(
    parameter int MD_LAT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic MdStartE,
    input  logic PCSrcE,
    output logic mdStall,
    output logic MdBusy
);

    localparam int            CW      = $clog2(MD_LAT);
    localparam logic [CW-1:0] MD_INIT = CW'(MD_LAT - 2);
    localparam logic [CW-1:0] MD_ONE  = CW'(1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;
    logic          launch;

    // A taken branch squashes the op in E, so it must not start the sequence.
    assign launch = (state_q == IDLE) && MdStartE && !PCSrcE;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d  = BUSY;
                    md_cnt_d = MD_INIT;
                end
            end
            BUSY: begin
                if (md_cnt_q != '0) begin
                    md_cnt_d = md_cnt_q - MD_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mdStall = launch || ((state_q == BUSY) && (md_cnt_q != '0));
        MdBusy  = (state_q == BUSY);
    end

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard controller for the 5-stage core: forwarding, load-use stall, branch
// flush, multi-cycle E hold. Optional perf counters under HAZARD_PERF_CNT_EN.
module hazard_unit_mc
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             reset,
    hazard_unit_mc_if.slave  hz
);

    localparam logic [REG_AW-1:0] X0 = '0;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] src,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (src != X0 && we_m && rd_m == src) return FWD_M;
        if (src != X0 && we_w && rd_w == src) return FWD_W;
        return FWD_RF;
    endfunction

    logic lw_stall;
    logic md_stall;
    logic md_busy;

    hazard_md_timer #(.MD_LAT(MD_LAT)) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .MdStartE (hz.MdStartE),
        .PCSrcE   (hz.PCSrcE),
        .mdStall  (md_stall),
        .MdBusy   (md_busy)
    );

    assign lw_stall = hz.ResultSrcE[0] && (hz.RdE != X0) &&
                      ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));

    assign hz.ForwardAE = fwd_sel(hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    assign hz.ForwardBE = fwd_sel(hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);

    assign hz.lwStall = lw_stall;
    assign hz.MdBusy  = md_busy;
    assign hz.StallF  = lw_stall || md_stall;
    assign hz.StallD  = lw_stall || md_stall;
    assign hz.StallE  = md_stall;
    assign hz.FlushD  = hz.PCSrcE;
    // A held E stage must not be bubbled, even if a load-use hit coincides.
    assign hz.FlushE  = (lw_stall || hz.PCSrcE) && !md_stall;
    assign hz.FlushM  = md_stall;

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters: they stick at all-ones until reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (hz.StallF && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_ONE;
        if (hz.PCSrcE && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.StallCycles = stall_cnt_q;
    assign hz.FlushCount  = flush_cnt_q;
`else
    assign hz.StallCycles = {CNT_W{1'b0}};
    assign hz.FlushCount  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: per-cycle model comparison plus
// hand-computed literal expectations; honours HAZARD_PERF_CNT_EN.
module tb_hazard_unit_mc;

    localparam int REG_AW = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz();

    hazard_unit_mc #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // md_age: -1 when no op holds E, else how many cycles the op has sat in E.
    int md_age = -1;
    int exp_stall_cnt = 0;
    int exp_flush_cnt = 0;

    function automatic logic [1:0] m_fwd(input int src);
        if (src != 0 && hz.RegWriteM && int'(hz.RdM) == src) return 2'b10;
        if (src != 0 && hz.RegWriteW && int'(hz.RdW) == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit m_lw();
        return hz.ResultSrcE[0] && hz.RdE != 0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
    endfunction

    function automatic bit m_md(input int age);
        if (age < 0) return hz.MdStartE && !hz.PCSrcE;
        return age < MD_LAT - 1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            md_age        <= -1;
            exp_stall_cnt <= 0;
            exp_flush_cnt <= 0;
        end else begin
            if (md_age < 0)               md_age <= (hz.MdStartE && !hz.PCSrcE) ? 1 : -1;
            else if (md_age < MD_LAT - 1) md_age <= md_age + 1;
            else                          md_age <= -1;
            if (m_lw() || m_md(md_age))
                exp_stall_cnt <= (exp_stall_cnt == CMAX) ? CMAX : exp_stall_cnt + 1;
            if (hz.PCSrcE)
                exp_flush_cnt <= (exp_flush_cnt == CMAX) ? CMAX : exp_flush_cnt + 1;
        end
    end

    function automatic int exp_cnt(input int v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ForwardAE", hz.ForwardAE, m_fwd(int'(hz.Rs1E)));
            check("m_ForwardBE", hz.ForwardBE, m_fwd(int'(hz.Rs2E)));
            check("m_lwStall",   hz.lwStall,   m_lw());
            check("m_StallF",    hz.StallF,    m_lw() || m_md(md_age));
            check("m_StallD",    hz.StallD,    m_lw() || m_md(md_age));
            check("m_StallE",    hz.StallE,    m_md(md_age));
            check("m_FlushD",    hz.FlushD,    hz.PCSrcE);
            check("m_FlushE",    hz.FlushE,    (m_lw() || hz.PCSrcE) && !m_md(md_age));
            check("m_FlushM",    hz.FlushM,    m_md(md_age));
            check("m_MdBusy",    hz.MdBusy,    md_age >= 1);
            check("m_StallCycles", hz.StallCycles, exp_cnt(exp_stall_cnt));
            check("m_FlushCount",  hz.FlushCount,  exp_cnt(exp_flush_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic clear_in();
        hz.Rs1D = '0; hz.Rs2D = '0; hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0;
        hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.ResultSrcE = 2'b00; hz.MdStartE = 1'b0; hz.PCSrcE = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        clear_in();
        tick();
        tick();
        reset  = 1'b0;
        chk_en = 1'b1;

        // Reset state with all inputs low.
        mid();
        check("rst_ForwardAE", hz.ForwardAE, 0);
        check("rst_lwStall", hz.lwStall, 0);
        check("rst_MdBusy", hz.MdBusy, 0);
        check("rst_StallF", hz.StallF, 0);
        check("rst_FlushE", hz.FlushE, 0);
        check("rst_StallCycles", hz.StallCycles, 0);
        tick();

        // Forwarding priority and x0.
        hz.RdM = 5'd5; hz.RdW = 5'd5; hz.Rs1E = 5'd5;
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        mid(); check("fwd_M_prio", hz.ForwardAE, 2'b10); tick();
        hz.Rs1E = 5'd0;
        mid(); check("fwd_x0", hz.ForwardAE, 2'b00); tick();
        hz.Rs1E = 5'd5; hz.Rs2E = 5'd5; hz.RegWriteM = 1'b0;
        mid(); check("fwd_W_A", hz.ForwardAE, 2'b01); check("fwd_W_B", hz.ForwardBE, 2'b01); tick();
        hz.RdM = 5'd3; hz.RdW = 5'd4; hz.RegWriteM = 1'b1;
        for (int i = 0; i < 8; i++) begin
            hz.Rs1E = 5'(i);
            hz.Rs2E = 5'(7 - i);
            tick();
        end
        clear_in();

        // Load-use hazard, then load to x0.
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
        mid();
        check("lu_lwStall", hz.lwStall, 1);
        check("lu_StallF", hz.StallF, 1);
        check("lu_StallD", hz.StallD, 1);
        check("lu_FlushE", hz.FlushE, 1);
        check("lu_FlushM", hz.FlushM, 0);
        tick();
        hz.RdE = 5'd0;
        mid(); check("lu_x0_lwStall", hz.lwStall, 0); check("lu_x0_StallF", hz.StallF, 0); tick();
        clear_in();

        // Multi-cycle op with MdStartE held through release.
        hz.MdStartE = 1'b1;
        for (int k = 0; k < MD_LAT; k++) begin
            mid();
            check($sformatf("md_StallE_%0d", k), hz.StallE, (k < MD_LAT - 1) ? 1 : 0);
            check($sformatf("md_FlushM_%0d", k), hz.FlushM, (k < MD_LAT - 1) ? 1 : 0);
            check($sformatf("md_MdBusy_%0d", k), hz.MdBusy, (k > 0) ? 1 : 0);
            tick();
        end
        hz.MdStartE = 1'b0;
        mid(); check("md_noretrig_busy", hz.MdBusy, 0); check("md_noretrig_stall", hz.StallE, 0); tick();

        // Branch and multi-cycle start together: flush wins.
        hz.MdStartE = 1'b1; hz.PCSrcE = 1'b1;
        mid();
        check("bx_FlushD", hz.FlushD, 1);
        check("bx_FlushE", hz.FlushE, 1);
        check("bx_StallE", hz.StallE, 0);
        tick();
        clear_in();
        mid(); check("bx_MdBusy", hz.MdBusy, 0); tick();

        // Reset during the second BUSY cycle aborts the sequence.
        hz.MdStartE = 1'b1;
        tick();
        hz.MdStartE = 1'b0;
        mid(); check("rb_busy1", hz.MdBusy, 1); tick();
        reset = 1'b1;
        mid(); check("rb_busy2_stall", hz.StallE, 1); tick();
        reset = 1'b0;
        mid();
        check("rb_MdBusy", hz.MdBusy, 0);
        check("rb_StallE", hz.StallE, 0);
        check("rb_StallF", hz.StallF, 0);
        check("rb_StallCycles", hz.StallCycles, 0);
        tick();

        // Performance counters: 3 flushes, then 20 stall cycles (saturates at 15).
        hz.PCSrcE = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        clear_in();
        mid(); check("pc_FlushCount", hz.FlushCount, exp_cnt(3)); tick();
        hz.ResultSrcE = 2'b01; hz.RdE = 5'd7; hz.Rs1D = 5'd7;
        for (int k = 0; k < 20; k++) tick();
        clear_in();
        mid();
        check("pc_StallCycles_sat", hz.StallCycles, exp_cnt(15));
        check("pc_FlushCount_hold", hz.FlushCount, exp_cnt(3));
        tick();

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit_mc.md
# hazard_unit_mc

Pipeline hazard controller for the 5-stage RISC-V core with parametrised register-address width and support for a multi-cycle execute unit (mul/div) of configurable latency. It sits beside the datapath and produces the following signals every cycle:
- operand-forwarding selects for the E stage;
- load-use stalls;
- branch flushes;
- a counter-driven stall sequence that holds an E-stage multi-cycle op for `MD_LAT` cycles while inserting bubbles into M.

## Interface
Parameters:
- `REG_AW`, 5, register-address width.
- `MD_LAT`, 4, total cycles a multi-cycle op occupies E; legal range 2..255.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset.
- `Rs1D`, `Rs2D`  in  `REG_AW`  D-stage source registers.
- `Rs1E`, `Rs2E`, `RdE`  in  `REG_AW`  E-stage sources and destination.
- `RdM`, `RdW`  in  `REG_AW`  M- and W-stage destinations.
- `RegWriteM`, `RegWriteW`  in  1  M- and W-stage write enables.
- `ResultSrcE`  in  2  E-stage result select; bit 0 set means load.
- `MdStartE`  in  1  E-stage instruction is a multi-cycle op.
- `PCSrcE`  in  1  taken branch or jump resolved in E.
- `ForwardAE`, `ForwardBE`  out  2  select: 00 register file, 01 W, 10 M.
- `lwStall`  out  1  load-use hazard detected.
- `MdBusy`  out  1  multi-cycle sequence active (registered).
- `StallF`, `StallD`, `StallE`  out  1  hold F, D and E pipeline registers.
- `FlushD`, `FlushE`, `FlushM`  out  1  clear D, E and M pipeline registers.
- `StallCycles`, `FlushCount`  out  `CNT_W`  performance counters.

## Operation
Forwarding (combinational), evaluated separately for A/Rs1E and B/Rs2E:
- M match has priority: `RegWriteM` set, RdM equals the source, source non-zero → 10.
- Otherwise W match: `RegWriteW` set, RdW equals the source, source non-zero → 01.
- Otherwise → 00.

Load-use: `lwStall` = `ResultSrcE[0]` & (`RdE` != 0) & (`Rs1D`==`RdE` | `Rs2D`==`RdE`). Loads to x0 never stall.

Multi-cycle FSM, states IDLE and BUSY, with a down-counter `md_cnt` of width clog2(`MD_LAT`):
- IDLE & `MdStartE` & !`PCSrcE` → BUSY, `md_cnt` := `MD_LAT`-2.
- BUSY & `md_cnt`!=0 → `md_cnt` decrements.
- BUSY & `md_cnt`==0 → IDLE. `MdStartE` is ignored on this edge, so the same op never retriggers.
- `mdStall` = (IDLE & `MdStartE` & !`PCSrcE`) | (BUSY & `md_cnt`!=0).
- `MdBusy` = state==BUSY.

Output equations:
- `StallF` = `StallD` = `lwStall` | `mdStall`.
- `StallE` = `mdStall`.
- `FlushD` = `PCSrcE`.
- `FlushE` = (`lwStall` | `PCSrcE`) & !`mdStall`.
- `FlushM` = `mdStall`.

Boundary rules:
- `PCSrcE` and `MdStartE` together (illegal encoding): flush wins and the FSM stays in IDLE.
- `lwStall` and `mdStall` together: E holds, so `FlushE` is 0.

## Timing
- Forwarding, `lwStall` and all stall/flush outputs are same-cycle combinational from inputs and state. No latency.
- A multi-cycle op occupies E for exactly `MD_LAT` cycles: `MD_LAT`-1 stalled cycles, then one release cycle with `StallE`=0.
- `MdBusy` rises one cycle after `MdStartE` is first seen and falls on the release edge.
- Reset values: state IDLE, `md_cnt`=0, `MdBusy`=0, both counters 0. All combinational outputs are therefore 0 when inputs are 0.
- Reset mid-sequence aborts on the next edge: IDLE, no stall in the following cycle unless `MdStartE` is still high.

## Configuration
Macro `HAZARD_PERF_CNT_EN`.
- Defined:
  - `StallCycles` increments on every cycle with `StallF`=1.
  - `FlushCount` increments on every cycle with `PCSrcE`=1.
  - Both saturate at all-ones and clear on `reset`.
- Undefined: counter registers are not built; both ports are tied to 0. Ports remain present so instantiation is unchanged.

## Structure
- Package `hazard_pkg` holds:
  - forward-select constants `FWD_RF`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10;
  - the FSM state typedef (IDLE, BUSY).
- One sub-module, `hazard_md_timer`, contains the FSM and counter (`clk`, `reset`, `MdStartE`, `PCSrcE` → `mdStall`, `MdBusy`). Forwarding, load-use logic and the optional counters stay in the top.

## Test plan
- `RdM`=`RdW`=`Rs1E`=5, `RegWriteM`=`RegWriteW`=1 → `ForwardAE`=10. Repeat with `Rs1E`=0 → 00.
- Load in E (`ResultSrcE`=01, `RdE`=7), `Rs2D`=7 → `lwStall`, `StallF`, `StallD`, `FlushE` all 1, `FlushM`=0. Repeat with `RdE`=0 → no stall.
- `MD_LAT`=4, `MdStartE` held high → `StallE`=1 for exactly 3 cycles, `FlushM`=1 for those 3 cycles, `MdBusy` high 3 cycles, release on the 4th cycle, no retrigger.
- `MdStartE` and `PCSrcE` in the same cycle → `FlushD`=`FlushE`=1, `StallE`=0, `MdBusy` stays 0.
- Assert `reset` in the 2nd BUSY cycle → next cycle `MdBusy`=0 and all stalls 0 with `MdStartE` low.
- `HAZARD_PERF_CNT_EN` with `CNT_W`=4: 20 stall cycles → `StallCycles`=15 (saturated). Without the macro → 0.
